csa_mul_pipe: RTL

- Parametrised, 3-stage pipelined carry-save (Wallace) multiplier for the Tomasulo multiply functional unit.
- Generalises the fixed 32-bit combinational CSA reduction chain:
  - configurable operand width;
  - signed/unsigned mode per operation;
  - valid/ready handshake with back-pressure;
  - reservation-station tag carried alongside the data;
  - flush for misprediction recovery.
- Sits between the multiply reservation station (issue side) and the CDB arbiter (result side).

---
 rtl/csa_mul_pipe.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/csa_mul_pipe.sv
// 3-stage pipelined carry-save multiplier with valid/ready, tag and flush.
// Define CSA_MUL_PIPE_MUL_ACC_EN to add in_acc to the product.
package csa_mul_pipe_pkg;

  function automatic int csa_next(input int n);
    return (n / 3) * 2 + n % 3;
  endfunction

  function automatic int csa_layers(input int n, input int lim);
    int k;
    int m;
    k = 0;
    m = n;
    while (m > lim && k < 64) begin
      m = csa_next(m);
      k++;
    end
    return k;
  endfunction

  function automatic int csa_rows(input int n, input int l);
    int m;
    m = n;
    for (int i = 0; i < l; i++)
      m = csa_next(m);
    return m;
  endfunction

endpackage

module csa_mul_pipe_tree
  import csa_mul_pipe_pkg::*;
#(
  parameter int PW   = 8,
  parameter int NIN  = 7,
  parameter int LIM  = 6,
  parameter int NOUT = 5
) (
  input  logic [PW-1:0] i_row [NIN],
  output logic [PW-1:0] o_row [NOUT]
);

  localparam int NL = csa_layers(NIN, LIM);

  logic [PW-1:0] w_lv [NL+1][NIN];

  for (genvar r = 0; r < NIN; r++) begin : g_in
    assign w_lv[0][r] = i_row[r];
  end

  for (genvar l = 0; l < NL; l++) begin : g_lay
    localparam int N = csa_rows(NIN, l);
    localparam int G = N / 3;
    localparam int M = csa_next(N);

    for (genvar g = 0; g < G; g++) begin : g_fa
      logic [PW-1:0] w_x;
      logic [PW-1:0] w_y;
      logic [PW-1:0] w_z;
      logic [PW-1:0] w_maj;
      assign w_x   = w_lv[l][3*g];
      assign w_y   = w_lv[l][3*g+1];
      assign w_z   = w_lv[l][3*g+2];
      assign w_maj = (w_x & w_y) | (w_x & w_z) | (w_y & w_z);
      assign w_lv[l+1][2*g]   = w_x ^ w_y ^ w_z;
      assign w_lv[l+1][2*g+1] = {w_maj[PW-2:0], 1'b0};
    end

    for (genvar r = 0; r < N % 3; r++) begin : g_pass
      assign w_lv[l+1][2*G+r] = w_lv[l][3*G+r];
    end

    for (genvar r = M; r < NIN; r++) begin : g_pad
      assign w_lv[l+1][r] = '0;
    end
  end

  for (genvar r = 0; r < NOUT; r++) begin : g_out
    assign o_row[r] = w_lv[NL][r];
  end

endmodule

module csa_mul_pipe
  import csa_mul_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [2*WIDTH-1:0] in_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 3;
  localparam int L1 = csa_layers(NR, 6);
  localparam int N1 = csa_rows(NR, L1);
  localparam int L2 = csa_layers(N1, 2);
  localparam int N2 = csa_rows(N1, L2);

  logic [WIDTH:0]  w_ae;
  logic [WIDTH:0]  w_be;
  logic [PW-1:0]   w_asx;
  logic [PW-1:0]   w_pp   [NR];
  logic [PW-1:0]   w_s1_d [N1];
  logic [PW-1:0]   w_s2_d [N2];
  logic            w_adv;
  logic            w_unused;

  logic             r_s1_vld;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_sgn;
  logic [PW-1:0]    r_s1_row [N1];

  logic             r_s2_vld;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_sgn;
  logic [PW-1:0]    r_s2_sum;
  logic [PW-1:0]    r_s2_car;

  logic             r_s3_vld;
  logic [TAG_W-1:0] r_s3_tag;
  logic             r_s3_sgn;
  logic [PW-1:0]    r_s3_prod;

  assign w_adv    = !(r_s3_vld && !out_ready);
  assign in_ready = w_adv && !flush;

  assign w_ae  = {in_signed & in_a[WIDTH-1], in_a};
  assign w_be  = {in_signed & in_b[WIDTH-1], in_b};
  assign w_asx = {{(PW-WIDTH-1){w_ae[WIDTH]}}, w_ae};

  // Top multiplier bit has weight -2^WIDTH: add ~(A<<W) plus a +1 row.
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      w_pp[i] = w_be[i] ? (w_asx << i) : '0;
    w_pp[WIDTH]   = w_be[WIDTH] ? ~(w_asx << WIDTH) : '0;
    w_pp[WIDTH+1] = PW'(w_be[WIDTH]);
`ifdef CSA_MUL_PIPE_MUL_ACC_EN
    w_pp[WIDTH+2] = in_acc;
`else
    w_pp[WIDTH+2] = '0;
`endif
  end

`ifdef CSA_MUL_PIPE_MUL_ACC_EN
  assign w_unused = r_s3_sgn;
`else
  assign w_unused = ^{r_s3_sgn, in_acc};
`endif

  csa_mul_pipe_tree #(
    .PW   (PW),
    .NIN  (NR),
    .LIM  (6),
    .NOUT (N1)
  ) u_tree1 (
    .i_row (w_pp),
    .o_row (w_s1_d)
  );

  csa_mul_pipe_tree #(
    .PW   (PW),
    .NIN  (N1),
    .LIM  (2),
    .NOUT (N2)
  ) u_tree2 (
    .i_row (r_s1_row),
    .o_row (w_s2_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_tag  <= '0;
      r_s1_sgn  <= 1'b0;
      for (int i = 0; i < N1; i++)
        r_s1_row[i] <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_tag  <= '0;
      r_s2_sgn  <= 1'b0;
      r_s2_sum  <= '0;
      r_s2_car  <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_tag  <= '0;
      r_s3_sgn  <= 1'b0;
      r_s3_prod <= '0;
    end else if (flush) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
    end else if (w_adv) begin
      r_s1_vld  <= in_valid;
      r_s1_tag  <= in_tag;
      r_s1_sgn  <= in_signed;
      for (int i = 0; i < N1; i++)
        r_s1_row[i] <= w_s1_d[i];
      r_s2_vld  <= r_s1_vld;
      r_s2_tag  <= r_s1_tag;
      r_s2_sgn  <= r_s1_sgn;
      r_s2_sum  <= w_s2_d[0];
      r_s2_car  <= w_s2_d[1];
      r_s3_vld  <= r_s2_vld;
      r_s3_tag  <= r_s2_tag;
      r_s3_sgn  <= r_s2_sgn;
      r_s3_prod <= r_s2_sum + r_s2_car;
    end
  end

  assign out_valid   = r_s3_vld;
  assign out_product = r_s3_prod;
  assign out_tag     = r_s3_tag;

endmodule
